// File: rtl/qupls_sm_bus_arb_if.sv
// qupls_sm_bus_arb_if: FTA 64-bit command bus types plus the bundle tying two masters and one shared slave port to the arbiter.
// Signals: m0_req/m0_resp (stack machine), m1_req/m1_resp (auxiliary requester), s_req/s_resp (shared bus).
// Modport slave is the arbiter's view; modport master is the view of whatever drives the masters and the shared slave.
package qupls_sm_bus_arb_pkg;
    localparam logic [2:0] CTI_ERC = 3'b001;
    typedef struct packed {
        logic        cyc;
        logic        we;
        logic [2:0]  cti;
        logic [7:0]  sel;
        logic [31:0] padr;
        logic [63:0] dat;
    } fta_cmd_request64_t;
    typedef struct packed {
        logic        ack;
        logic        rty;
        logic        err;
        logic [63:0] dat;
    } fta_cmd_response64_t;
endpackage

interface qupls_sm_bus_arb_if;
    import qupls_sm_bus_arb_pkg::*;
    fta_cmd_request64_t  m0_req;
    fta_cmd_response64_t m0_resp;
    fta_cmd_request64_t  m1_req;
    fta_cmd_response64_t m1_resp;
    fta_cmd_request64_t  s_req;
    fta_cmd_response64_t s_resp;
    modport slave  (input m0_req, m1_req, s_resp, output m0_resp, m1_resp, s_req);
    modport master (output m0_req, m1_req, s_resp, input m0_resp, m1_resp, s_req);
endinterface

// File: rtl/qupls_sm_bus_arb.sv
// qupls_sm_bus_arb: two-master arbiter forwarding one FTA command at a time to a shared bus, with retry and response timeout.
// Ports: clk_i clock; rst_ni async active-low reset; bus arbiter side of qupls_sm_bus_arb_if; busy_o high while a transaction is outstanding.
module qupls_sm_bus_arb
    import qupls_sm_bus_arb_pkg::*;
#(
    parameter int          TIMEOUT = 255,
    parameter logic [63:0] TO_DATA = 64'hDEADDEADDEADDEAD
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    qupls_sm_bus_arb_if.slave    bus,
    output logic                 busy_o
);
    typedef enum logic [1:0] {IDLE, ISSUED, WAIT_ACK} state_t;

    state_t              state_q;
    logic                owner_q, last_q, rty0_q, rty1_q, need_ack_q, to_fire_q;
    logic [15:0]         to_cnt_q;
    logic                r0, r1, gnt, gv, rty0_d, rty1_d;
    fta_cmd_response64_t own;

    always_comb begin
        r0 = bus.m0_req.cyc;
        r1 = bus.m1_req.cyc;
        // on a tie the master that did not win last time gets the bus
        gnt = (r0 & r1) ? ~last_q : r1;
        gv = (state_q == IDLE) & (r0 | r1);
        bus.s_req = gv ? (gnt ? bus.m1_req : bus.m0_req) : '0;
        rty0_d = r0 & ~(gv & ~gnt);
        rty1_d = r1 & ~(gv & gnt);
        // a fired timeout completes in the IDLE cycle after WAIT_ACK, when the slave is no longer routed
        own = '0;
        own.ack = to_fire_q;
        own.dat = to_fire_q ? TO_DATA : '0;
        if (state_q != IDLE) own = bus.s_resp;
        bus.m0_resp = owner_q ? '0 : own;
        bus.m0_resp.rty = bus.m0_resp.rty | rty0_q;
        bus.m1_resp = owner_q ? own : '0;
        bus.m1_resp.rty = bus.m1_resp.rty | rty1_q;
        busy_o = state_q != IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            rty0_q     <= 1'b0;
            rty1_q     <= 1'b0;
            need_ack_q <= 1'b0;
            to_fire_q  <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            rty0_q    <= rty0_d;
            rty1_q    <= rty1_d;
            to_fire_q <= 1'b0;
            case (state_q)
                IDLE: if (gv) begin
                    owner_q    <= gnt;
                    last_q     <= gnt;
                    need_ack_q <= ~bus.s_req.we | (bus.s_req.cti == CTI_ERC);
                    state_q    <= ISSUED;
                end
                ISSUED: if (bus.s_resp.rty || !need_ack_q) begin
                    state_q <= IDLE;
                end else begin
                    state_q  <= WAIT_ACK;
                    to_cnt_q <= '0;
                end
                WAIT_ACK: begin
                    to_cnt_q <= to_cnt_q + 16'd1;
                    if (bus.s_resp.ack) begin
                        state_q <= IDLE;
                    end else if (to_cnt_q == 16'(TIMEOUT - 1)) begin
                        state_q   <= IDLE;
                        to_fire_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qupls_sm_bus_arb.sv
// tb_qupls_sm_bus_arb: scoreboard bench for qupls_sm_bus_arb; expected responses are queued as stimulus is driven and matched as they appear.
module tb_qupls_sm_bus_arb;
    import qupls_sm_bus_arb_pkg::*;

    localparam logic [63:0] TOD = 64'hDEADDEADDEADDEAD;

    typedef struct {
        int          c;
        int          m;
        logic        ack;
        logic        rty;
        logic [63:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic busy;
    int   total = 0;
    int   bad = 0;
    int   cyc_n = 0;
    int   busy_n = 0;
    int   k;
    exp_t q[$];
    fta_cmd_request64_t ra, rb;

    always #5 clk = ~clk;

    qupls_sm_bus_arb_if bus();

    qupls_sm_bus_arb #(.TIMEOUT(4), .TO_DATA(TOD)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus),
        .busy_o(busy)
    );

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(int c, int m, logic a, logic r, logic [63:0] d);
        exp_t e;
        e.c = c; e.m = m; e.ack = a; e.rty = r; e.dat = d;
        q.push_back(e);
    endtask

    function automatic fta_cmd_request64_t rq(logic we, logic [2:0] cti, logic [31:0] a, logic [63:0] d);
        rq = '0;
        rq.cyc = 1'b1; rq.we = we; rq.cti = cti; rq.sel = '1; rq.padr = a; rq.dat = d;
    endfunction

    function automatic fta_cmd_response64_t rs(logic a, logic r, logic [63:0] d);
        rs = '0;
        rs.ack = a; rs.rty = r; rs.dat = d;
    endfunction

    task automatic mon(int m, fta_cmd_response64_t r);
        exp_t e;
        if (r != '0) begin
            if (q.size() == 0) chk($sformatf("unexpected_resp_m%0d", m), r, '0);
            else begin
                e = q.pop_front();
                chk($sformatf("cycle_master_m%0d", m), {32'(cyc_n), 32'(m)}, {32'(e.c), 32'(e.m)});
                chk($sformatf("ack_m%0d", m), r.ack, e.ack);
                chk($sformatf("rty_m%0d", m), r.rty, e.rty);
                chk($sformatf("err_m%0d", m), r.err, 1'b0);
                chk($sformatf("dat_m%0d", m), r.dat, e.dat);
            end
        end
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (busy) busy_n++;
        mon(0, bus.m0_resp);
        mon(1, bus.m1_resp);
    end

    initial begin
        bus.m0_req = '0; bus.m1_req = '0; bus.s_resp = '0;
        repeat (2) tick;
        rst_ni = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sreq", bus.s_req, '0);
        chk("rst_m0", bus.m0_resp, '0);
        chk("rst_m1", bus.m1_resp, '0);
        // joint pulse after reset: m0 first, then m1
        tick;
        ra = rq(1'b1, 3'd0, 32'hFF000200, 64'h1); rb = rq(1'b1, 3'd0, 32'hFF000300, 64'h2);
        bus.m0_req = ra; bus.m1_req = rb; k = cyc_n;
        push(k + 1, 1, 1'b0, 1'b1, '0);
        @(negedge clk); chk("tie1_sreq", bus.s_req, ra);
        tick; bus.m0_req = '0; bus.m1_req = '0;
        tick; bus.m0_req = ra; bus.m1_req = rb;
        push(k + 3, 0, 1'b0, 1'b1, '0);
        @(negedge clk); chk("tie2_sreq", bus.s_req, rb);
        tick; bus.m0_req = '0; bus.m1_req = '0;
        repeat (2) tick;
        // single read from m0, slave acks in the fourth busy cycle
        ra = rq(1'b0, 3'd0, 32'hFF000100, '0);
        bus.m0_req = ra; k = cyc_n; busy_n = 0;
        @(negedge clk); chk("rd_sreq", bus.s_req, ra);
        tick; bus.m0_req = '0;
        repeat (3) tick;
        bus.s_resp = rs(1'b1, 1'b0, 64'h1122334455667788);
        push(k + 4, 0, 1'b1, 1'b0, 64'h1122334455667788);
        tick; bus.s_resp = '0;
        tick; chk("rd_busy", busy_n, 4);
        // posted write from m1 needs no ack
        rb = rq(1'b1, 3'd0, 32'hFF000400, 64'hA5);
        bus.m1_req = rb; busy_n = 0;
        @(negedge clk); chk("pw_sreq", bus.s_req, rb);
        tick; bus.m1_req = '0;
        repeat (2) tick; chk("pw_busy", busy_n, 1);
        // ERC write from m1 waits for ack
        rb = rq(1'b1, CTI_ERC, 32'hFF000500, 64'hB6);
        bus.m1_req = rb; k = cyc_n; busy_n = 0;
        tick; bus.m1_req = '0;
        tick; bus.s_resp = rs(1'b1, 1'b0, 64'h77);
        push(k + 2, 1, 1'b1, 1'b0, 64'h77);
        tick; bus.s_resp = '0;
        tick; chk("erc_busy", busy_n, 2);
        // slave retry then re-issue accepted
        ra = rq(1'b0, 3'd0, 32'hFF000600, '0);
        bus.m0_req = ra; k = cyc_n;
        tick; bus.m0_req = '0; bus.s_resp = rs(1'b0, 1'b1, '0);
        push(k + 1, 0, 1'b0, 1'b1, '0);
        tick; bus.s_resp = '0; bus.m0_req = ra;
        @(negedge clk); chk("reissue_sreq", bus.s_req, ra);
        tick; bus.m0_req = '0;
        tick; bus.s_resp = rs(1'b1, 1'b0, 64'hCAFE);
        push(k + 4, 0, 1'b1, 1'b0, 64'hCAFE);
        tick; bus.s_resp = '0;
        tick;
        // timeout: slave never acks; m1 retried meanwhile; late ack dropped
        bus.m0_req = rq(1'b0, 3'd0, 32'hFF000700, '0); k = cyc_n; busy_n = 0;
        tick; bus.m0_req = '0;
        repeat (2) tick;
        bus.m1_req = rq(1'b0, 3'd0, 32'hFF000800, '0);
        push(k + 4, 1, 1'b0, 1'b1, '0);
        tick; bus.m1_req = '0;
        repeat (2) tick;
        push(k + 6, 0, 1'b1, 1'b0, TOD);
        tick; bus.s_resp = rs(1'b1, 1'b0, 64'h55);
        tick; bus.s_resp = '0;
        chk("to_busy", busy_n, 5);
        tick;
        // async reset in WAIT_ACK, then m0 wins the tie again
        bus.m0_req = rq(1'b0, 3'd0, 32'hFF000900, '0);
        tick; bus.m0_req = '0;
        tick; #2;
        rst_ni = 1'b0;
        bus.s_resp = rs(1'b1, 1'b0, 64'h99);
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_m0", bus.m0_resp, '0);
        chk("arst_sreq", bus.s_req, '0);
        tick; bus.s_resp = '0;
        tick; rst_ni = 1'b1;
        tick;
        ra = rq(1'b1, 3'd0, 32'hFF000A00, 64'h3); rb = rq(1'b1, 3'd0, 32'hFF000B00, 64'h4);
        bus.m0_req = ra; bus.m1_req = rb;
        push(cyc_n + 1, 1, 1'b0, 1'b1, '0);
        @(negedge clk); chk("arst_tie_sreq", bus.s_req, ra);
        tick; bus.m0_req = '0; bus.m1_req = '0;
        repeat (3) tick;
        chk("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
